// File: rtl/peripheral_display_seq.sv
// peripheral_display_seq
//   Display stage placed after the operand loader. It drives four active-low
//   7-segment digits. While the loader is taking input, the switch byte is
//   echoed. When the loader reports ready, the A/B/R words are captured and
//   then shown one byte at a time. Each enter pulse moves to the next byte.
//   An optional timer can also step through the bytes automatically.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-high reset
//   enterpulse       one-cycle, already-debounced advance request
//   loaddata         1 = operand loading mode (highest priority)
//   inputdata[7:0]   switch byte echoed while loading
//   inputdata_ready  loader has completed A/B/R
//   dataA/B/R[31:0]  words to display (captured on entry to SHOW)
//   disp3..disp0     registered segment outputs {g,f,e,d,c,b,a}, active-low
//
// Parameters
//   AUTO_CYCLES      auto-advance period in clk cycles; 0 disables auto-scroll
//   TW               width of the auto-scroll counter
module peripheral_display_seq #(
  parameter int AUTO_CYCLES = 0,
  parameter int TW          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enterpulse,
  input  logic        loaddata,
  input  logic [7:0]  inputdata,
  input  logic        inputdata_ready,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [31:0] dataR,
  output logic [6:0]  disp3,
  output logic [6:0]  disp2,
  output logic [6:0]  disp1,
  output logic [6:0]  disp0
);

  typedef enum logic [1:0] {S_WAIT, S_LOAD, S_SHOW} state_t;

  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam bit         AUTO_EN   = (AUTO_CYCLES > 0);
  localparam logic [TW-1:0] AUTO_LAST = AUTO_EN ? TW'(AUTO_CYCLES - 1) : '0;

  function automatic logic [6:0] seg_hex(input logic [3:0] n);
    case (n)
      4'h0: seg_hex = 7'h40;  4'h1: seg_hex = 7'h79;
      4'h2: seg_hex = 7'h24;  4'h3: seg_hex = 7'h30;
      4'h4: seg_hex = 7'h19;  4'h5: seg_hex = 7'h12;
      4'h6: seg_hex = 7'h02;  4'h7: seg_hex = 7'h78;
      4'h8: seg_hex = 7'h00;  4'h9: seg_hex = 7'h10;
      4'hA: seg_hex = 7'h08;  4'hB: seg_hex = 7'h03;
      4'hC: seg_hex = 7'h46;  4'hD: seg_hex = 7'h21;
      4'hE: seg_hex = 7'h06;  default: seg_hex = 7'h0E;
    endcase
  endfunction

  state_t          state, next_state;
  logic [1:0]      word_sel, byte_sel;   // word_sel: 0=A, 1=B, 2=R
  logic [TW-1:0]   auto_cnt;
  logic [31:0]     snap_a, snap_b, snap_r;

  logic            enter_show;
  logic            auto_expire;
  logic            advance;
  logic [31:0]     sel_word;
  logic [7:0]      sel_byte;
  logic [6:0]      d3_n, d2_n, d1_n, d0_n;

  // Next-state logic. loaddata has priority over every other condition.
  // In SHOW, a falling ready flag is deliberately ignored.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    if (loaddata) begin
      next_state = S_LOAD;
    end else begin
      case (state)
        S_LOAD:  next_state = inputdata_ready ? S_SHOW : S_WAIT;
        S_WAIT:  next_state = inputdata_ready ? S_SHOW : S_WAIT;
        default: next_state = S_SHOW;
      endcase
    end
  end

  assign enter_show  = (state != S_SHOW) && (next_state == S_SHOW);
  assign auto_expire = AUTO_EN && (state == S_SHOW) && (auto_cnt == AUTO_LAST);
  // If enter and the timer expiry fall in the same cycle, the byte still
  // advances only once.
  assign advance     = (state == S_SHOW) && (next_state == S_SHOW) && (enterpulse || auto_expire);

  always_comb begin
    sel_word = snap_a;
    case (word_sel)
      2'd1:    sel_word = snap_b;
      2'd2:    sel_word = snap_r;
      default: sel_word = snap_a;
    endcase
    sel_byte = sel_word[8*byte_sel +: 8];
  end

  // Digit content is computed from the current state and then registered,
  // so the digits appear one clock after the state/index change.
  always_comb begin
    d3_n = SEG_DASH;
    d2_n = SEG_DASH;
    d1_n = SEG_DASH;
    d0_n = SEG_DASH;
    case (state)
      S_LOAD: begin
        d3_n = SEG_L;
        d2_n = SEG_BLANK;
        d1_n = seg_hex(inputdata[7:4]);
        d0_n = seg_hex(inputdata[3:0]);
      end
      S_SHOW: begin
        d3_n = (word_sel == 2'd0) ? SEG_A : (word_sel == 2'd1) ? SEG_B : SEG_R;
        d2_n = seg_hex({2'b00, byte_sel});
        d1_n = seg_hex(sel_byte[7:4]);
        d0_n = seg_hex(sel_byte[3:0]);
      end
      default: ;
    endcase
  end

  // The snapshot registers are plain flops. They are reset along with the
  // rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT;
      word_sel <= 2'd0;
      byte_sel <= 2'd0;
      auto_cnt <= '0;
      snap_a   <= '0;
      snap_b   <= '0;
      snap_r   <= '0;
      disp3    <= SEG_DASH;
      disp2    <= SEG_DASH;
      disp1    <= SEG_DASH;
      disp0    <= SEG_DASH;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      disp3 <= d3_n;
      disp2 <= d2_n;
      disp1 <= d1_n;
      disp0 <= d0_n;

      if (enter_show) begin
        snap_a   <= dataA;
        snap_b   <= dataB;
        snap_r   <= dataR;
        word_sel <= 2'd0;
        byte_sel <= 2'd0;
      end else if (advance) begin
        byte_sel <= byte_sel + 2'd1;
        if (byte_sel == 2'd3) begin
          word_sel <= (word_sel == 2'd2) ? 2'd0 : word_sel + 2'd1;
        end
      end

      // The timer runs only while showing. An enter pulse restarts it.
      if (!AUTO_EN || enter_show || state != S_SHOW || enterpulse || auto_expire) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_display_seq.sv
// Directed testbench for peripheral_display_seq. It builds two instances from
// the same inputs: dut (enter-only) and dut_auto (AUTO_CYCLES=4). Inputs
// change 1 time unit after a rising edge, and outputs are sampled at that
// same point.
module tb_peripheral_display_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        enterpulse;
  logic        loaddata;
  logic [7:0]  inputdata;
  logic        inputdata_ready;
  logic [31:0] dataA, dataB, dataR;
  logic [6:0]  disp3, disp2, disp1, disp0;
  logic [6:0]  a_disp3, a_disp2, a_disp1, a_disp0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  peripheral_display_seq #(.AUTO_CYCLES(0), .TW(32)) dut (
    .clk(clk), .reset(reset), .enterpulse(enterpulse), .loaddata(loaddata),
    .inputdata(inputdata), .inputdata_ready(inputdata_ready),
    .dataA(dataA), .dataB(dataB), .dataR(dataR),
    .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
  );

  peripheral_display_seq #(.AUTO_CYCLES(4), .TW(8)) dut_auto (
    .clk(clk), .reset(reset), .enterpulse(enterpulse), .loaddata(loaddata),
    .inputdata(inputdata), .inputdata_ready(inputdata_ready),
    .dataA(dataA), .dataB(dataB), .dataR(dataR),
    .disp3(a_disp3), .disp2(a_disp2), .disp1(a_disp1), .disp0(a_disp0)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter(input int n);
    for (int i = 0; i < n; i++) begin
      enterpulse = 1'b1;
      step(1);
      enterpulse = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [27:0] pk(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  logic [27:0] obs_main, obs_auto;
  assign obs_main = {disp3, disp2, disp1, disp0};
  assign obs_auto = {a_disp3, a_disp2, a_disp1, a_disp0};

  initial begin
    reset = 1'b1; enterpulse = 1'b0; loaddata = 1'b0; inputdata = 8'h00;
    inputdata_ready = 1'b0; dataA = '0; dataB = '0; dataR = '0;
    step(2);
    check("reset_disp", obs_main, pk(7'h3F, 7'h3F, 7'h3F, 7'h3F));
    reset = 1'b0;
    step(1);
    enter(1);
    step(2);
    check("wait_enter_ignored", obs_main, pk(7'h3F, 7'h3F, 7'h3F, 7'h3F));

    // Load mode echoes the switch byte
    loaddata = 1'b1; inputdata = 8'h3F;
    step(2);
    check("load_3F", obs_main, pk(7'h47, 7'h7F, 7'h30, 7'h0E));
    inputdata = 8'hA1;
    step(1);
    check("load_A1", obs_main, pk(7'h47, 7'h7F, 7'h08, 7'h79));
    enter(1);
    step(1);
    check("load_enter_ignored", obs_main, pk(7'h47, 7'h7F, 7'h08, 7'h79));

    // Show mode
    dataA = 32'h3F800000; dataB = 32'hA1BE867D; dataR = 32'h12345678;
    loaddata = 1'b0; inputdata_ready = 1'b1;
    step(2);
    check("show_A0", obs_main, pk(7'h08, 7'h40, 7'h40, 7'h40));
    enter(3); step(1);
    check("show_A3", obs_main, pk(7'h08, 7'h30, 7'h30, 7'h0E));
    enter(1); step(1);
    check("show_B0", obs_main, pk(7'h03, 7'h40, 7'h78, 7'h21));
    enter(1); step(1);
    check("show_B1", obs_main, pk(7'h03, 7'h79, 7'h00, 7'h02));
    enter(3); step(1);
    check("show_R0", obs_main, pk(7'h2F, 7'h40, 7'h78, 7'h00));
    enter(4); step(1);
    check("show_wrapA0", obs_main, pk(7'h08, 7'h40, 7'h40, 7'h40));

    // Captured words are held, and dropping ready is ignored
    dataA = 32'hFFFFFFFF; inputdata_ready = 1'b0;
    step(2);
    check("snapshot_held", obs_main, pk(7'h08, 7'h40, 7'h40, 7'h40));
    inputdata_ready = 1'b1;
    loaddata = 1'b1; step(1);
    loaddata = 1'b0; step(2);
    check("reentry_A0_FF", obs_main, pk(7'h08, 7'h40, 7'h0E, 7'h0E));

    // Reset while showing
    enter(10); step(1);
    check("show_R2", obs_main, pk(7'h2F, 7'h24, 7'h30, 7'h19));
    reset = 1'b1;
    #1;
    check("reset_async", obs_main, pk(7'h3F, 7'h3F, 7'h3F, 7'h3F));
    step(1);
    check("reset_held", obs_main, pk(7'h3F, 7'h3F, 7'h3F, 7'h3F));
    reset = 1'b0;
    step(2);
    check("after_reset_A0", obs_main, pk(7'h08, 7'h40, 7'h0E, 7'h0E));

    // Auto-scroll on dut_auto (period 4), starting again from a fresh reset
    reset = 1'b1; step(1);
    reset = 1'b0;
    step(2);
    check("auto_A0", obs_auto, pk(7'h08, 7'h40, 7'h0E, 7'h0E));
    step(3);
    check("auto_A0_hold", obs_auto, pk(7'h08, 7'h40, 7'h0E, 7'h0E));
    step(1);
    check("auto_A1", obs_auto, pk(7'h08, 7'h79, 7'h0E, 7'h0E));
    step(3);
    check("auto_A1_hold", obs_auto, pk(7'h08, 7'h79, 7'h0E, 7'h0E));
    step(1);
    check("auto_A2", obs_auto, pk(7'h08, 7'h24, 7'h0E, 7'h0E));
    // Enter lands on the same cycle as a timer expiry: one advance only
    step(2);
    enter(1); step(1);
    check("auto_enter_expiry_A3", obs_auto, pk(7'h08, 7'h30, 7'h0E, 7'h0E));
    step(2);
    check("auto_A3_hold", obs_auto, pk(7'h08, 7'h30, 7'h0E, 7'h0E));
    step(2);
    check("auto_B0", obs_auto, pk(7'h03, 7'h40, 7'h78, 7'h21));
    // Enter away from an expiry restarts the timer
    enter(1); step(1);
    check("auto_enter_B1", obs_auto, pk(7'h03, 7'h79, 7'h00, 7'h02));
    step(2);
    check("auto_cnt_restart", obs_auto, pk(7'h03, 7'h79, 7'h00, 7'h02));
    step(2);
    check("auto_B2", obs_auto, pk(7'h03, 7'h24, 7'h03, 7'h06));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
